uart_tx: RTL

- Serial transmitter that consumes the Core's result bytes (Tx_DV/Tx_Byte) and drives the UART TX line, framed 8N1 (1 start, 8 data LSB-first, 1 stop).
- Returns a one-cycle Tx_Done_out pulse, which feeds the Core's Tx_Done_in. The controller uses this pulse to sequence the MSB byte, then the LSB byte, of the adder result.
- Sits directly downstream of the Core, beside the existing UART receiver, at the top level.

---
 rtl/uart_tx.sv | 109 ++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte from the Core while idle and shifts it out LSB first.
// Tx_Done_out pulses once at the end of the stop bit so the Core can sequence its next byte.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tx_DV_in,
    input  logic [7:0] Tx_Byte_in,
    output logic       Tx_Serial_out,
    output logic       Tx_Active_out,
    output logic       Tx_Done_out
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             serial_q,  serial_d;
    logic             active_q,  active_d;
    logic             done_q,    done_d;
    logic             bit_end;

    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                // The line falls on the accepting edge, so the frame is timed from here.
                if (Tx_DV_in) begin
                    state_d  = START;
                    shift_d  = Tx_Byte_in;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    serial_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    // shift_q[0] is always the bit on the line; the next one sits in [1].
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Tx_Serial_out = serial_q;
    assign Tx_Active_out = active_q;
    assign Tx_Done_out   = done_q;

endmodule
